// File: rtl/tqvp_pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tqvp_pwm_fade_ctrl
//   PWM generator with hardware fade engine.  A free-running 8-bit counter
//   defines 256-cycle PWM periods.  The fade engine walks DUTY toward TARGET
//   in STEP-sized increments, one step every PRESCALE+1 periods, and raises
//   done on arrival.  Optional breathe mode bounces between TARGET and the
//   DUTY value captured at start.
//
//   Build option: define TQVP_PWM_FADE_BREATHE_EN to compile breathe mode
//   (CTRL bit2 = loop).  Without it, loop reads 0 and REVERSE is unreachable.
//
// Ports
//   clk        : clock, rising-edge
//   rst_n      : synchronous active-low reset
//   ui_in      : unused, connected for pinout compatibility
//   uo_out     : [0] PWM, [1] busy, [2] done, [7:3] zero
//   address    : register select
//   data_write : one-cycle write strobe
//   data_in    : write data
//   data_out   : combinational read data (unmapped addresses read 0x00)
//
// Register map
//   0x0 CTRL     W: bit0 start, bit1 abort, bit2 loop   R: {5'b0, loop, 2'b0}
//   0x1 TARGET   0x2 STEP   0x3 PRESCALE   0x4 DUTY
//   0x5 STATUS   R: {4'b0, state, done, busy}           W: bit1=1 clears done
// -----------------------------------------------------------------------------
module tqvp_pwm_fade_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RAMP    = 2'b01,
      REVERSE = 2'b10
   } state_t;

   localparam logic [3:0] ADDR_CTRL     = 4'h0;
   localparam logic [3:0] ADDR_TARGET   = 4'h1;
   localparam logic [3:0] ADDR_STEP     = 4'h2;
   localparam logic [3:0] ADDR_PRESCALE = 4'h3;
   localparam logic [3:0] ADDR_DUTY     = 4'h4;
   localparam logic [3:0] ADDR_STATUS   = 4'h5;

   state_t     state_q, state_d;
   logic [7:0] duty_q, duty_d;
   logic [7:0] pwm_duty_q, pwm_duty_d;
   logic [7:0] target_q, target_d;
   logic [7:0] step_q, step_d;
   logic [7:0] prescale_q, prescale_d;
   logic [7:0] pscnt_q, pscnt_d;
   logic [7:0] base_q, base_d;
   logic [7:0] cnt_q;
   logic       done_q, done_d;
   logic       loop_q;

   logic       unused_ui;
   assign unused_ui = ^ui_in;

   // Register decode
   logic wr_ctrl, start, abort, wrap, busy;
   assign wr_ctrl = data_write && (address == ADDR_CTRL);
   assign start   = wr_ctrl && data_in[0];
   assign abort   = wr_ctrl && data_in[1];
   assign wrap    = (cnt_q == 8'hFF);
   assign busy    = (state_q != IDLE);

`ifdef TQVP_PWM_FADE_BREATHE_EN
   logic loop_d;

   always_comb begin
      loop_d = loop_q;
      if (wr_ctrl) loop_d = data_in[2];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) loop_q <= 1'b0;
      else        loop_q <= loop_d;
   end
`else
   assign loop_q = 1'b0;
`endif

   // Step arithmetic: 9-bit sums so overshoot/underflow clamps to the goal
   // instead of wrapping through 0 or 255.
   logic [7:0] step_eff, goal, stepped;
   logic [8:0] sum9, diff9;

   always_comb begin
      step_eff = (step_q == 8'd0) ? 8'd1 : step_q;
      goal     = (state_q == REVERSE) ? base_q : target_q;
      sum9     = {1'b0, duty_q} + {1'b0, step_eff};
      diff9    = {1'b0, duty_q} - {1'b0, step_eff};
      stepped  = goal;
      if (duty_q < goal) begin
         stepped = (sum9 > {1'b0, goal}) ? goal : sum9[7:0];
      end else if (duty_q > goal) begin
         stepped = (diff9[8] || (diff9[7:0] < goal)) ? goal : diff9[7:0];
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      target_d   = target_q;
      step_d     = step_q;
      prescale_d = prescale_q;
      pscnt_d    = pscnt_q;
      base_d     = base_q;
      done_d     = done_q;

      if (data_write) begin
         case (address)
            ADDR_TARGET:   target_d   = data_in;
            ADDR_STEP:     step_d     = data_in;
            ADDR_PRESCALE: prescale_d = data_in;
            ADDR_DUTY:     if (state_q == IDLE) duty_d = data_in;
            ADDR_STATUS:   if (data_in[1]) done_d = 1'b0;
            default: ;
         endcase
      end

      // Abort outranks start; both outrank a step decision on the same
      // cycle.  A done set from a step lands after the clear above, so set
      // wins over a coincident clear.
      if (abort) begin
         state_d = IDLE;
      end else if (start) begin
         state_d = RAMP;
         done_d  = 1'b0;
         pscnt_d = '0;
         base_d  = duty_q;
      end else if (busy && wrap) begin
         if (pscnt_q == prescale_q) begin
            pscnt_d = '0;
            duty_d  = stepped;
            if (stepped == goal) begin
               case (state_q)
                  RAMP: begin
                     done_d  = 1'b1;
                     state_d = loop_q ? REVERSE : IDLE;
                  end
                  REVERSE: begin
                     if (loop_q) begin
                        state_d = RAMP;
                     end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end
                  end
                  default: state_d = IDLE;
               endcase
            end
         end else begin
            pscnt_d = pscnt_q + 8'd1;
         end
      end

      // The comparator uses a shadow copy loaded only at the period
      // boundary, so every PWM period sees a single duty value.
      pwm_duty_d = wrap ? duty_d : pwm_duty_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         duty_q     <= '0;
         pwm_duty_q <= '0;
         target_q   <= '0;
         step_q     <= 8'd1;
         prescale_q <= '0;
         pscnt_q    <= '0;
         base_q     <= '0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         pwm_duty_q <= pwm_duty_d;
         target_q   <= target_d;
         step_q     <= step_d;
         prescale_q <= prescale_d;
         pscnt_q    <= pscnt_d;
         base_q     <= base_d;
         done_q     <= done_d;
         cnt_q      <= cnt_q + 8'd1;
      end
   end

   // Outputs
   logic pwm;
   assign pwm    = (cnt_q < pwm_duty_q);
   assign uo_out = {5'b0, done_q, busy, pwm};

   always_comb begin
      data_out = '0;
      case (address)
         ADDR_CTRL:     data_out = {5'b0, loop_q, 2'b0};
         ADDR_TARGET:   data_out = target_q;
         ADDR_STEP:     data_out = step_q;
         ADDR_PRESCALE: data_out = prescale_q;
         ADDR_DUTY:     data_out = duty_q;
         ADDR_STATUS:   data_out = {4'b0, state_q, done_q, busy};
         default:       data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_tqvp_pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tqvp_pwm_fade_ctrl
//   Scoreboard bench: stimulus pushes expected values, a negedge monitor pops
//   and compares whenever a check strobe is raised.  Breathe-mode vectors are
//   compiled when TQVP_PWM_FADE_BREATHE_EN is defined.
// -----------------------------------------------------------------------------
module tb_tqvp_pwm_fade_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;

   tqvp_pwm_fade_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ui_in      (ui_in),
      .uo_out     (uo_out),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   localparam int K_RD  = 0;
   localparam int K_UO  = 1;
   localparam int K_PWM = 2;

   typedef struct {
      int    kind;
      int    exp;
      string name;
   } chk_t;

   chk_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic chk_req = 1'b0;
   int   pwm_high = 0;
   logic [7:0] tb_cnt = '0;

   // Reference period counter, follows the specified cnt behaviour.
   always @(posedge clk) begin
      if (!rst_n) tb_cnt <= '0;
      else        tb_cnt <= tb_cnt + 8'd1;
   end

   // Monitor
   always @(negedge clk) begin
      if (chk_req) begin
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry");
         end else begin
            chk_t e;
            int   act;
            e = sb.pop_front();
            case (e.kind)
               K_RD:    act = int'(data_out);
               K_UO:    act = int'(uo_out);
               default: act = pwm_high;
            endcase
            checks++;
            if (act != e.exp) begin
               errors++;
               $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic expect_val(input int kind, input logic [3:0] a, input int exp, input string name);
      chk_t e;
      e.kind = kind;
      e.exp  = exp;
      e.name = name;
      address = a;
      sb.push_back(e);
      chk_req = 1'b1;
      @(posedge clk);
      #1;
      chk_req = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      @(posedge clk);
      #1;
      data_write = 1'b0;
   endtask

   // Returns #1 after the edge on which the period counter wrapped to 0.
   task automatic wait_after_wrap();
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (tb_cnt != 8'd0 && n < 300);
      if (tb_cnt != 8'd0) begin
         errors++;
         $display("FAIL wrap_timeout: counter at %0d expected 0", tb_cnt);
      end
   endtask

   task automatic measure_period();
      pwm_high = 0;
      for (int i = 0; i < 256; i++) begin
         if (uo_out[0]) pwm_high++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   initial begin
      int exp_duty [8];
      exp_duty = '{8'h00, 8'h04, 8'h04, 8'h08, 8'h08, 8'h0C, 8'h0C, 8'h10};

      rst_n      = 1'b0;
      ui_in      = 8'hA5;
      address    = '0;
      data_write = 1'b0;
      data_in    = '0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      expect_val(K_UO, 4'h0, 8'h00, "rst_uo_out");
      expect_val(K_RD, 4'h0, 8'h00, "rst_ctrl");
      expect_val(K_RD, 4'h1, 8'h00, "rst_target");
      expect_val(K_RD, 4'h2, 8'h01, "rst_step");
      expect_val(K_RD, 4'h3, 8'h00, "rst_prescale");
      expect_val(K_RD, 4'h4, 8'h00, "rst_duty");
      expect_val(K_RD, 4'h5, 8'h00, "rst_status");
      expect_val(K_RD, 4'h9, 8'h00, "unmapped_read");

      // Idle PWM at 0x40: 64 high cycles per 256
      wr(4'h4, 8'h40);
      expect_val(K_RD, 4'h4, 8'h40, "duty_write");
      wait_after_wrap();
      measure_period();
      expect_val(K_PWM, 4'h0, 64, "pwm_high_period1");
      wait_after_wrap();
      measure_period();
      expect_val(K_PWM, 4'h0, 64, "pwm_high_period2");

      // Ramp 0 -> 0x10, step 4, prescale 1
      wait_after_wrap();
      wr(4'h4, 8'h00);
      wr(4'h1, 8'h10);
      wr(4'h2, 8'h04);
      wr(4'h3, 8'h01);
      wr(4'h0, 8'h01);
      expect_val(K_RD, 4'h5, 8'h05, "ramp_start_status");
      for (int k = 0; k < 8; k++) begin
         wait_after_wrap();
         if (k == 1) expect_val(K_UO, 4'h0, 8'h03, "ramp_uo_busy");
         expect_val(K_RD, 4'h4, exp_duty[k], $sformatf("ramp_duty_w%0d", k + 1));
         if (k < 7) expect_val(K_RD, 4'h5, 8'h05, $sformatf("ramp_status_w%0d", k + 1));
      end
      expect_val(K_UO, 4'h0, 8'h05, "ramp_done_uo");
      expect_val(K_RD, 4'h5, 8'h02, "ramp_done_status");
      wr(4'h5, 8'h02);
      expect_val(K_RD, 4'h5, 8'h00, "done_clear");

      // Saturation at 0xFF
      wait_after_wrap();
      wr(4'h4, 8'hF0);
      wr(4'h1, 8'hFF);
      wr(4'h2, 8'h20);
      wr(4'h3, 8'h00);
      wr(4'h0, 8'h01);
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'hFF, "sat_up_duty");
      expect_val(K_RD, 4'h5, 8'h02, "sat_up_status");

      // STEP=0 behaves as 1 (downward)
      wait_after_wrap();
      wr(4'h1, 8'hFD);
      wr(4'h2, 8'h00);
      expect_val(K_RD, 4'h2, 8'h00, "step_zero_read");
      wr(4'h0, 8'h01);
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'hFE, "step0_duty_w1");
      expect_val(K_RD, 4'h5, 8'h05, "step0_status_w1");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'hFD, "step0_duty_w2");
      expect_val(K_RD, 4'h5, 8'h02, "step0_status_w2");

      // Downward clamp at 0
      wait_after_wrap();
      wr(4'h1, 8'h00);
      wr(4'h2, 8'hF0);
      wr(4'h0, 8'h01);
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h0D, "sat_dn_duty_w1");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h00, "sat_dn_duty_w2");
      expect_val(K_RD, 4'h5, 8'h02, "sat_dn_status");

      // Start+abort together mid-ramp
      wait_after_wrap();
      wr(4'h1, 8'h80);
      wr(4'h2, 8'h10);
      wr(4'h0, 8'h01);
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h10, "abort_pre_w1");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h20, "abort_pre_w2");
      wr(4'h0, 8'h03);
      expect_val(K_RD, 4'h5, 8'h00, "abort_status");
      expect_val(K_RD, 4'h4, 8'h20, "abort_duty");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h20, "abort_duty_frozen");

      // DUTY writes ignored while busy
      wr(4'h1, 8'h40);
      wr(4'h3, 8'h03);
      wr(4'h0, 8'h01);
      wr(4'h4, 8'h99);
      expect_val(K_RD, 4'h4, 8'h20, "busy_duty_ignored");
      expect_val(K_RD, 4'h5, 8'h05, "busy_status");
      wr(4'h0, 8'h02);
      expect_val(K_RD, 4'h5, 8'h00, "abort_only_status");

`ifdef TQVP_PWM_FADE_BREATHE_EN
      // Breathe 8 <-> 24, step 8
      wait_after_wrap();
      wr(4'h4, 8'h08);
      wr(4'h1, 8'h18);
      wr(4'h2, 8'h08);
      wr(4'h3, 8'h00);
      wr(4'h0, 8'h05);
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h10, "breathe_duty_w1");
      expect_val(K_RD, 4'h5, 8'h05, "breathe_status_w1");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h18, "breathe_duty_w2");
      expect_val(K_RD, 4'h5, 8'h0B, "breathe_status_w2");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h10, "breathe_duty_w3");
      expect_val(K_RD, 4'h5, 8'h0B, "breathe_status_w3");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h08, "breathe_duty_w4");
      expect_val(K_RD, 4'h5, 8'h07, "breathe_status_w4");
      wait_after_wrap();
      expect_val(K_RD, 4'h4, 8'h10, "breathe_duty_w5");
      expect_val(K_RD, 4'h0, 8'h04, "breathe_ctrl_loop");
      wr(4'h0, 8'h02);
      expect_val(K_RD, 4'h5, 8'h02, "breathe_abort_status");
      expect_val(K_RD, 4'h4, 8'h10, "breathe_abort_duty");
`else
      wr(4'h0, 8'h04);
      expect_val(K_RD, 4'h0, 8'h00, "loop_disabled_ctrl");
      expect_val(K_RD, 4'h5, 8'h00, "loop_disabled_status");
`endif

      // Reset mid-ramp
      wr(4'h4, 8'h30);
      wr(4'h1, 8'h90);
      wr(4'h0, 8'h01);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_val(K_RD, 4'h5, 8'h00, "midramp_rst_status");
      expect_val(K_RD, 4'h4, 8'h00, "midramp_rst_duty");
      expect_val(K_RD, 4'h1, 8'h00, "midramp_rst_target");
      expect_val(K_UO, 4'h0, 8'h00, "midramp_rst_uo");

      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
